// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: loadable program memory feeding the execute unit one
// instruction every two cycles, with a NOP bubble while the redirect resolves.
module instr_fetch #(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned ADDR_W    = 6,
  parameter logic [31:0] HALT_WORD = 32'hFC000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic              start,
  input  logic [31:0]       PCnew,
  output logic [31:0]       ins,
  output logic [31:0]       PC,
  output logic              valid,
  output logic              halted,
  output logic [15:0]       icount
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] RESOLVE = 2'd2;
  localparam logic [1:0] HALT    = 2'd3;

  logic [31:0] mem [DEPTH];

  logic [1:0]  state_q, state_d;
  logic [31:0] ins_q, ins_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic [15:0] icount_q, icount_d;

  logic        idle_like;
  logic        load_ok;
  logic        start_ok;
  logic        load_in_range;
  logic [31:0] next_pc;
  logic        next_in_range;
  logic [31:0] next_word;
  logic [15:0] icount_inc;

  assign idle_like     = (state_q == IDLE) || (state_q == HALT);
  assign load_ok       = idle_like && load_en;
  // A load in the same cycle as start wins; start is dropped.
  assign start_ok      = idle_like && start && !load_en;
  assign load_in_range = {{(32-ADDR_W){1'b0}}, load_addr} < DEPTH;

  // Zero on PCnew means fall through; the execute unit never targets address 0.
  assign next_pc       = (PCnew != 32'd0) ? PCnew : pc_q + 32'd1;
  assign next_in_range = next_pc < DEPTH;
  assign next_word     = next_in_range ? mem[next_pc[ADDR_W-1:0]] : HALT_WORD;
  assign icount_inc    = (icount_q == 16'hFFFF) ? icount_q : icount_q + 16'd1;

  always_ff @(posedge clk) begin
    if (!rst && load_ok && load_in_range) begin
      mem[load_addr] <= load_data;
    end
  end

  always_comb begin
    state_d  = state_q;
    ins_d    = ins_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    icount_d = icount_q;
    case (state_q)
      IDLE, HALT: begin
        if (start_ok) begin
          icount_d = 16'd0;
          halted_d = 1'b0;
          pc_d     = 32'd0;
          if (mem[0] == HALT_WORD) begin
            ins_d    = 32'd0;
            valid_d  = 1'b0;
            halted_d = 1'b1;
            state_d  = HALT;
          end else begin
            ins_d    = mem[0];
            valid_d  = 1'b1;
            icount_d = 16'd1;
            state_d  = ISSUE;
          end
        end
      end
      ISSUE: begin
        ins_d   = 32'd0;
        valid_d = 1'b0;
        state_d = RESOLVE;
      end
      RESOLVE: begin
        if (!next_in_range || next_word == HALT_WORD) begin
          ins_d    = 32'd0;
          valid_d  = 1'b0;
          halted_d = 1'b1;
          state_d  = HALT;
        end else begin
          ins_d    = next_word;
          pc_d     = next_pc;
          valid_d  = 1'b1;
          icount_d = icount_inc;
          state_d  = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ins_q    <= 32'd0;
      pc_q     <= 32'd0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      icount_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      ins_q    <= ins_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      icount_q <= icount_d;
    end
  end

  assign ins    = ins_q;
  assign PC     = pc_q;
  assign valid  = valid_q;
  assign halted = halted_q;
  assign icount = icount_q;

endmodule
